// File: rtl/ahb_lite_led_responder.sv
// AHB-Lite subordinate with a four-register file: LED control, synchronised
// switch status, 32-bit scratch and completed-write counter. It inserts
// programmable data-phase wait states and answers illegal accesses with the
// two-cycle ERROR response.
module ahb_lite_led_responder #(
   parameter int WAIT_STATES = 0,
   parameter int LED_W       = 4,
   parameter int SW_W        = 2,
   parameter int DEC_W       = 12
) (
   input  logic              hclk,
   input  logic              hresetn,
   input  logic              hsel,
   input  logic [31:0]       haddr,
   input  logic [1:0]        htrans,
   input  logic              hwrite,
   input  logic [2:0]        hsize,
   input  logic [2:0]        hburst,
   input  logic [3:0]        hprot,
   input  logic              hmastlock,
   input  logic [31:0]       hwdata,
   input  logic              hready,
   output logic              hreadyout,
   output logic              hresp,
   output logic [31:0]       hrdata,
   output logic [LED_W-1:0]  led,
   input  logic [SW_W-1:0]   sw
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ERR1 = 2'd2,
      ST_ERR2 = 2'd3
   } state_t;

   localparam bit         HAS_WAIT  = (WAIT_STATES != 0);
   localparam logic [3:0] WAIT_LOAD = WAIT_STATES[3:0];

   // Address-phase legality: mapped offset, legal size, natural alignment and
   // no writes to the read-only words (offsets 0x4 and 0xC, i.e. bit 2 set).
   function automatic logic addr_err(input logic [DEC_W-1:0] off,
                                     input logic             wr,
                                     input logic [2:0]       size);
      logic unmapped;
      logic bad_size;
      logic misaligned;
      logic ro_write;
      unmapped = (off[DEC_W-1:4] != {(DEC_W-4){1'b0}});
      ro_write = wr & off[2];
      case (size)
         3'd0: begin
            bad_size   = 1'b0;
            misaligned = 1'b0;
         end
         3'd1: begin
            bad_size   = 1'b0;
            misaligned = off[0];
         end
         3'd2: begin
            bad_size   = 1'b0;
            misaligned = (off[1:0] != 2'b00);
         end
         default: begin
            bad_size   = 1'b1;
            misaligned = 1'b0;
         end
      endcase
      return unmapped | ro_write | bad_size | misaligned;
   endfunction

   // Byte lanes touched by a legal transfer, little-endian.
   function automatic logic [3:0] lane_strobe(input logic [1:0] addr_lo,
                                              input logic [1:0] size);
      logic [3:0] strb;
      case (size)
         2'd0:    strb = 4'b0001 << addr_lo;
         2'd1:    strb = addr_lo[1] ? 4'b1100 : 4'b0011;
         default: strb = 4'b1111;
      endcase
      return strb;
   endfunction

   // Replace only the strobed byte lanes of the old word.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
      logic [31:0] merged;
      for (int i = 0; i < 4; i++) begin
         merged[8*i +: 8] = strb[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
      end
      return merged;
   endfunction

   state_t             state_r;
   logic [3:0]         wait_cnt_r;
   logic               hreadyout_r;
   logic               hresp_r;

   logic               dp_ok_r;
   logic               dp_write_r;
   logic [3:0]         dp_addr_r;
   logic [1:0]         dp_size_r;

   logic [LED_W-1:0]   led_r;
   logic [31:0]        scratch_r;
   logic [31:0]        xfer_cnt_r;
   logic [SW_W-1:0]    sw_meta_r;
   logic [SW_W-1:0]    sw_sync_r;

   logic               accept_s;
   logic               err_s;
   logic               commit_s;
   logic               rd_phase_s;
   logic [31:0]        rd_word_s;
   logic [31:0]        wr_word_s;
   logic [31:0]        hrdata_s;
   logic               unused_s;

   // Sideband controls and undecoded address bits carry no meaning here.
   assign unused_s = ^{hburst, hprot, hmastlock, haddr[31:DEC_W]};

   // A new address phase is only taken while our previous data phase is
   // finishing (hreadyout high) and the bus itself is ready.
   assign accept_s   = hsel & hready & htrans[1] & hreadyout_r;
   assign err_s      = addr_err(haddr[DEC_W-1:0], hwrite, hsize);
   assign commit_s   = dp_ok_r & dp_write_r & hreadyout_r & ~hresp_r;
   assign rd_phase_s = dp_ok_r & ~dp_write_r & hreadyout_r & ~hresp_r;

   assign hreadyout = hreadyout_r;
   assign hresp     = hresp_r;
   assign hrdata    = hrdata_s;
   assign led       = led_r;

   // Response FSM: wait-state counting, two-cycle ERROR, registered handshake.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         state_r     <= ST_IDLE;
         wait_cnt_r  <= 4'd0;
         hreadyout_r <= 1'b1;
         hresp_r     <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE, ST_ERR2: begin
               if (accept_s && err_s) begin
                  state_r     <= ST_ERR1;
                  hreadyout_r <= 1'b0;
                  hresp_r     <= 1'b1;
               end else if (accept_s && HAS_WAIT) begin
                  state_r     <= ST_WAIT;
                  wait_cnt_r  <= WAIT_LOAD;
                  hreadyout_r <= 1'b0;
                  hresp_r     <= 1'b0;
               end else begin
                  state_r     <= ST_IDLE;
                  hreadyout_r <= 1'b1;
                  hresp_r     <= 1'b0;
               end
            end
            ST_WAIT: begin
               if (wait_cnt_r <= 4'd1) begin
                  state_r     <= ST_IDLE;
                  wait_cnt_r  <= 4'd0;
                  hreadyout_r <= 1'b1;
                  hresp_r     <= 1'b0;
               end else begin
                  wait_cnt_r  <= wait_cnt_r - 4'd1;
               end
            end
            ST_ERR1: begin
               state_r     <= ST_ERR2;
               hreadyout_r <= 1'b1;
               hresp_r     <= 1'b1;
            end
            default: begin
               state_r     <= ST_IDLE;
               wait_cnt_r  <= 4'd0;
               hreadyout_r <= 1'b1;
               hresp_r     <= 1'b0;
            end
         endcase
      end
   end

   // Data-phase capture; held while we stall, cleared once a phase completes.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         dp_ok_r    <= 1'b0;
         dp_write_r <= 1'b0;
         dp_addr_r  <= 4'd0;
         dp_size_r  <= 2'd0;
      end else if (hreadyout_r) begin
         dp_ok_r <= accept_s & ~err_s;
         if (accept_s) begin
            dp_write_r <= hwrite;
            dp_addr_r  <= haddr[3:0];
            dp_size_r  <= hsize[1:0];
         end else begin
            dp_write_r <= dp_write_r;
            dp_addr_r  <= dp_addr_r;
            dp_size_r  <= dp_size_r;
         end
      end else begin
         dp_ok_r    <= dp_ok_r;
         dp_write_r <= dp_write_r;
         dp_addr_r  <= dp_addr_r;
         dp_size_r  <= dp_size_r;
      end
   end

   // Register read mux, zero-extending the narrow LED and switch fields.
   always_comb begin
      rd_word_s = 32'd0;
      case (dp_addr_r[3:2])
         2'd0:    rd_word_s[LED_W-1:0] = led_r;
         2'd1:    rd_word_s[SW_W-1:0]  = sw_sync_r;
         2'd2:    rd_word_s            = scratch_r;
         2'd3:    rd_word_s            = xfer_cnt_r;
         default: rd_word_s            = 32'd0;
      endcase
   end

   // Merged write word and read data gated to completed OKAY read phases.
   always_comb begin
      wr_word_s = lane_merge(rd_word_s, hwdata, lane_strobe(dp_addr_r[1:0], dp_size_r));
      if (rd_phase_s) begin
         hrdata_s = rd_word_s;
      end else begin
         hrdata_s = 32'd0;
      end
   end

   // Writable registers and the completed-write counter commit together.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         led_r      <= {LED_W{1'b0}};
         scratch_r  <= 32'd0;
         xfer_cnt_r <= 32'd0;
      end else if (commit_s) begin
         xfer_cnt_r <= xfer_cnt_r + 32'd1;
         case (dp_addr_r[3:2])
            2'd0:    led_r     <= wr_word_s[LED_W-1:0];
            2'd2:    scratch_r <= wr_word_s;
            default: scratch_r <= scratch_r;
         endcase
      end else begin
         led_r      <= led_r;
         scratch_r  <= scratch_r;
         xfer_cnt_r <= xfer_cnt_r;
      end
   end

   // Two-flop synchroniser for the asynchronous switch inputs.
   always_ff @(posedge hclk or negedge hresetn) begin
      if (!hresetn) begin
         sw_meta_r <= {SW_W{1'b0}};
         sw_sync_r <= {SW_W{1'b0}};
      end else begin
         sw_meta_r <= sw;
         sw_sync_r <= sw_meta_r;
      end
   end

endmodule
